rt_gray_ptr_sync: RTL and testbench
===================================

Name: rt_gray_ptr_sync

Overview:
Receiver for a gray-coded count produced by the rt_bin_cnt → rt_bin2gray chain in another clock domain.
- Resynchronises the asynchronous gray bus into rt_i_clk through a multi-flop chain.
- Checks that consecutive samples differ by at most one bit.
- Converts the sample to binary and reports step events with direction.
- Sits at the consuming end of a gray pointer crossing, e.g. the FIFO read/write-pointer compare logic.

Parameters:
PARAM_BIT_NUM, 32, width of gray input and binary output (≥2).
PARAM_SYNC_STG, 2, number of synchroniser flops (≥2).
PARAM_ECNT_W, 8, width of saturating error counter.

Ports:
rt_i_clk  in  1  receiving-domain clock
rt_i_rst_n  in  1  asynchronous active-low reset
rt_i_gray  in  PARAM_BIT_NUM  gray count from foreign domain, asynchronous to rt_i_clk
rt_i_clr  in  1  synchronous clear of error state, restarts INIT
rt_o_bin  out  PARAM_BIT_NUM  registered binary value of synchronised gray
rt_o_vld  out  1  one-cycle pulse: a legal single step was received
rt_o_dir  out  1  direction of last legal step (0 increment, 1 decrement)
rt_o_eqnz  out  1  1 when rt_o_bin != 0
rt_o_err  out  1  sticky: multi-bit change detected
rt_o_err_cnt  out  PARAM_ECNT_W  saturating count of multi-bit changes
rt_o_rdy  out  1  1 when in RUN state

Behaviour:
- Reset: asynchronous and active-low. While rt_i_rst_n=0, all sync flops, prev_gray, rt_o_bin, rt_o_vld, rt_o_dir, rt_o_err, rt_o_err_cnt and rt_o_rdy are 0, and eqnz is 0. The FSM is in INIT. Reset is released internally as-is; the upstream system guarantees release is synchronous to rt_i_clk.
- Sync chain: rt_i_gray passes through PARAM_SYNC_STG flops, giving g_s. There is no logic between the flops.
- Conversion: rt_o_bin <= gray2bin(g_s) every cycle, in every state.
  - Latency from a stable rt_i_gray change to rt_o_bin is PARAM_SYNC_STG+1 cycles.
  - rt_o_eqnz is combinational from rt_o_bin.
- prev_gray <= g_s every cycle. Define d = g_s ^ prev_gray and popcount(d) = number of set bits in d.
- FSM INIT:
  - A down-counter loaded with PARAM_SYNC_STG+1 decrements each cycle; at 0 the FSM goes to RUN.
  - No vld or err generation in INIT. rt_o_rdy=0.
- FSM RUN, evaluated each cycle, with rt_o_rdy=1:
  - popcount(d)=0: no event; rt_o_vld=0.
  - popcount(d)=1: rt_o_vld=1 for exactly one cycle, aligned with the updated rt_o_bin.
    - rt_o_dir=1 iff new_bin == old_bin − 1 (mod 2^N), else 0.
    - rt_o_dir holds its value between steps.
  - popcount(d)≥2: rt_o_vld=0; rt_o_err<=1 (sticky); rt_o_err_cnt increments and saturates at all-ones. rt_o_dir is unchanged.
- Wrap-around:
  - Binary all-ones→0 (gray 100..0→000..0) is a legal step with dir=0.
  - Binary 0→all-ones is a legal step with dir=1.
- rt_i_clr=1 (synchronous):
  - On the next edge, err and err_cnt go to 0 and the FSM goes to INIT with the counter reloaded; rt_o_vld=0 that cycle.
  - Sync chain, prev_gray and rt_o_bin keep tracking.
  - clr wins over a simultaneous error or step event in the same cycle.
- Reset asserted mid-operation: immediate clear of all state per the reset rule, independent of clock.
- rt_o_vld and the err update are registered outputs from the same cycle's comparison: one cycle after g_s changes, aligned with rt_o_bin.

Decomposition:
- Shared package/include rt_graycode_pkg holds:
  - FSM state encodings ST_INIT=1'b0 and ST_RUN=1'b1.
  - Default width constant DEF_BIT_NUM=32.
  - A popcount-is-one/≥2 helper function shared with the other graycode blocks.
- Sub-modules:
  - Instantiate the existing rt_gray2bin for the conversion.
  - Add one new sub-module, rt_sync_chain (parameters PARAM_BIT_NUM and PARAM_SYNC_STG, async active-low reset), reusable for other crossing buses.

Test Plan:
1. Reset behaviour. With PARAM_BIT_NUM=4 and STG=2, hold rt_i_rst_n=0 with rt_i_gray=4'b0110, then release. Required: outputs stay 0 for 3 cycles with rdy=0, rt_o_bin=4 once INIT ends, rdy=1, and no vld pulse.
2. Increment sequence. Drive rt_bin_cnt→rt_bin2gray counting up 0..20 in a slower clock domain. Required: each step gives exactly one vld pulse with dir=0, rt_o_bin tracks the count delayed 3 cycles, and err=0.
3. Wrap, 4-bit. Steps 14→15→0→15 (gray 1001→1000→0000→1000). Required: vld three times with dir 0,0,1, and rt_o_eqnz=0 only while bin=0.
4. Multi-bit jump. In RUN, jump gray 0000→0011. Required: vld=0, err=1 and err_cnt=1. Repeat 300 jumps with PARAM_ECNT_W=8. Required: err_cnt saturates at 255.
5. Clear with a simultaneous error. Assert rt_i_clr in the same cycle as a 2-bit change. Required: err=0, err_cnt=0, rdy=0 for 3 cycles, then rdy=1.
6. Reset mid-stream. Pull rt_i_rst_n low between clock edges while counting down. Required: all outputs 0 immediately; after release, INIT lasts 3 cycles and then down-counting resumes with dir=1.

Source files
------------

// File: rtl/rt_graycode_pkg.sv
// Shared definitions for the graycode crossing blocks.
//   state_t     : receiver FSM encoding (ST_INIT / ST_RUN)
//   pc_class_t  : bit-change classification of a gray delta
//   pc_classify : sorts a delta into zero / exactly-one / two-or-more set bits
package rt_graycode_pkg;

  localparam int DEF_BIT_NUM = 32;
  // Widest delta pc_classify accepts; narrower buses are zero-extended.
  localparam int MAX_BIT_NUM = 64;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    PC_ZERO  = 2'd0,
    PC_ONE   = 2'd1,
    PC_MULTI = 2'd2
  } pc_class_t;

  localparam logic [MAX_BIT_NUM-1:0] PC_LSB = MAX_BIT_NUM'(1);

  // Clearing the lowest set bit leaves zero exactly when one bit was set.
  function automatic pc_class_t pc_classify(input logic [MAX_BIT_NUM-1:0] d);
    pc_class_t cls;
    if (d == '0)
      cls = PC_ZERO;
    else if ((d & (d - PC_LSB)) == '0)
      cls = PC_ONE;
    else
      cls = PC_MULTI;
    return cls;
  endfunction

endpackage

// File: rtl/rt_gray2bin.sv
// Combinational gray-to-binary converter.
//   rt_i_gray : gray-coded value
//   rt_o_bin  : binary equivalent
module rt_gray2bin #(
  parameter int PARAM_BIT_NUM = 32
) (
  input  logic [PARAM_BIT_NUM-1:0] rt_i_gray,
  output logic [PARAM_BIT_NUM-1:0] rt_o_bin
);

  // Each binary bit is the XOR of its gray bit and every gray bit above it.
  // NOTE: assign a default before the loop so no path leaves the output unassigned (no latch).
  always_comb begin
    rt_o_bin = '0;
    for (int i = 0; i < PARAM_BIT_NUM; i++)
      rt_o_bin[i] = ^(rt_i_gray >> i);
  end

endmodule

// File: rtl/rt_sync_chain.sv
// Multi-flop synchroniser for a bus that is already safe to sample bitwise
// (e.g. gray-coded). No logic between stages.
//   rt_i_clk   : receiving-domain clock
//   rt_i_rst_n : asynchronous active-low reset
//   rt_i_d     : asynchronous input bus
//   rt_o_q     : synchronised bus, PARAM_SYNC_STG cycles later
module rt_sync_chain #(
  parameter int PARAM_BIT_NUM  = 32,
  parameter int PARAM_SYNC_STG = 2
) (
  input  logic                     rt_i_clk,
  input  logic                     rt_i_rst_n,
  input  logic [PARAM_BIT_NUM-1:0] rt_i_d,
  output logic [PARAM_BIT_NUM-1:0] rt_o_q
);

  logic [PARAM_BIT_NUM-1:0] stg_q [PARAM_SYNC_STG];

  // NOTE: the stage array is a set of real flops, not RAM, so every entry is reset.
  // NOTE: non-blocking assignments make each stage capture the previous stage's old value.
  always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
    if (!rt_i_rst_n) begin
      for (int i = 0; i < PARAM_SYNC_STG; i++)
        stg_q[i] <= '0;
    end else begin
      stg_q[0] <= rt_i_d;
      for (int i = 1; i < PARAM_SYNC_STG; i++)
        stg_q[i] <= stg_q[i-1];
    end
  end

  assign rt_o_q = stg_q[PARAM_SYNC_STG-1];

endmodule

// File: rtl/rt_gray_ptr_sync.sv
// Receiver for a gray-coded counter from a foreign clock domain.
// Synchronises the bus, converts it to binary, flags legal single steps with
// direction, and counts illegal multi-bit changes.
//   rt_i_clk, rt_i_rst_n : clock, asynchronous active-low reset
//   rt_i_gray            : foreign-domain gray count
//   rt_i_clr             : synchronous clear of error state, restarts INIT
//   rt_o_bin             : registered binary value of the synchronised gray
//   rt_o_vld / rt_o_dir  : one-cycle legal-step pulse / last step direction (1 = down)
//   rt_o_eqnz            : rt_o_bin is non-zero
//   rt_o_err / rt_o_err_cnt : sticky multi-bit flag / saturating count
//   rt_o_rdy             : FSM is in RUN
// PARAM_BIT_NUM must not exceed MAX_BIT_NUM from the package.
module rt_gray_ptr_sync
  import rt_graycode_pkg::*;
#(
  parameter int PARAM_BIT_NUM  = DEF_BIT_NUM,
  parameter int PARAM_SYNC_STG = 2,
  parameter int PARAM_ECNT_W   = 8
) (
  input  logic                     rt_i_clk,
  input  logic                     rt_i_rst_n,
  input  logic [PARAM_BIT_NUM-1:0] rt_i_gray,
  input  logic                     rt_i_clr,
  output logic [PARAM_BIT_NUM-1:0] rt_o_bin,
  output logic                     rt_o_vld,
  output logic                     rt_o_dir,
  output logic                     rt_o_eqnz,
  output logic                     rt_o_err,
  output logic [PARAM_ECNT_W-1:0]  rt_o_err_cnt,
  output logic                     rt_o_rdy
);

  localparam int CNT_W = $clog2(PARAM_SYNC_STG + 2);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PARAM_SYNC_STG + 1);

  logic [PARAM_BIT_NUM-1:0] g_s;
  logic [PARAM_BIT_NUM-1:0] prev_gray;
  logic [PARAM_BIT_NUM-1:0] bin_new;
  logic [MAX_BIT_NUM-1:0]   diff_ext;
  pc_class_t                pc;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     vld_d, dir_d, err_d;
  logic [PARAM_ECNT_W-1:0]  err_cnt_d;

  rt_sync_chain #(
    .PARAM_BIT_NUM  (PARAM_BIT_NUM),
    .PARAM_SYNC_STG (PARAM_SYNC_STG)
  ) u_sync (
    .rt_i_clk   (rt_i_clk),
    .rt_i_rst_n (rt_i_rst_n),
    .rt_i_d     (rt_i_gray),
    .rt_o_q     (g_s)
  );

  rt_gray2bin #(
    .PARAM_BIT_NUM (PARAM_BIT_NUM)
  ) u_g2b (
    .rt_i_gray (g_s),
    .rt_o_bin  (bin_new)
  );

  // Datapath tracks g_s in every state and through clr.
  // rt_o_bin therefore always equals gray2bin(prev_gray): the "old" value for dir.
  always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
    if (!rt_i_rst_n) begin
      prev_gray <= '0;
      rt_o_bin  <= '0;
    end else begin
      prev_gray <= g_s;
      rt_o_bin  <= bin_new;
    end
  end

  assign diff_ext = MAX_BIT_NUM'(g_s ^ prev_gray);
  assign pc       = pc_classify(diff_ext);

  always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
    if (!rt_i_rst_n) begin
      state_q      <= ST_INIT;
      cnt_q        <= CNT_LOAD;
      rt_o_vld     <= 1'b0;
      rt_o_dir     <= 1'b0;
      rt_o_err     <= 1'b0;
      rt_o_err_cnt <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rt_o_vld     <= vld_d;
      rt_o_dir     <= dir_d;
      rt_o_err     <= err_d;
      rt_o_err_cnt <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vld_d     = 1'b0;
    dir_d     = rt_o_dir;
    err_d     = rt_o_err;
    err_cnt_d = rt_o_err_cnt;

    if (rt_i_clr) begin
      // clr overrides any step or error seen this cycle.
      state_d   = ST_INIT;
      cnt_d     = CNT_LOAD;
      err_d     = 1'b0;
      err_cnt_d = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          // Leave INIT on the edge where the counter reaches zero, giving the
          // sync chain and prev_gray time to fill with real samples.
          if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1))
            state_d = ST_RUN;
        end
        ST_RUN: begin
          case (pc)
            PC_ONE: begin
              vld_d = 1'b1;
              dir_d = (bin_new == (rt_o_bin - PARAM_BIT_NUM'(1)));
            end
            PC_MULTI: begin
              err_d = 1'b1;
              if (rt_o_err_cnt != '1)
                err_cnt_d = rt_o_err_cnt + PARAM_ECNT_W'(1);
            end
            default: ;
          endcase
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  assign rt_o_eqnz = (rt_o_bin != '0);
  assign rt_o_rdy  = (state_q == ST_RUN);

endmodule

// File: tb/tb_rt_gray_ptr_sync.sv
module tb_rt_gray_ptr_sync;

  localparam int N  = 4;
  localparam int EW = 8;

  logic          tb_r_clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic [N-1:0]  gray;
  logic [N-1:0]  bin;
  logic          vld, dir, eqnz, err, rdy;
  logic [EW-1:0] err_cnt;

  int total = 0;
  int bad   = 0;

  always #5 tb_r_clk = ~tb_r_clk;

  rt_gray_ptr_sync #(
    .PARAM_BIT_NUM  (N),
    .PARAM_SYNC_STG (2),
    .PARAM_ECNT_W   (EW)
  ) dut (
    .rt_i_clk     (tb_r_clk),
    .rt_i_rst_n   (rst_n),
    .rt_i_gray    (gray),
    .rt_i_clr     (clr),
    .rt_o_bin     (bin),
    .rt_o_vld     (vld),
    .rt_o_dir     (dir),
    .rt_o_eqnz    (eqnz),
    .rt_o_err     (err),
    .rt_o_err_cnt (err_cnt),
    .rt_o_rdy     (rdy)
  );

  task automatic tick;
    @(posedge tb_r_clk);
    #1;
  endtask

  function automatic logic [N-1:0] b2g(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reset with a given gray on the bus, then wait out INIT (3 cycles).
  task automatic apply_reset(input logic [N-1:0] g);
    rst_n = 1'b0;
    clr   = 1'b0;
    gray  = g;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clr   = 1'b0;
    gray  = 4'b0110;
    tick;
    tick;
    total++;
    if ({bin, vld, dir, eqnz, err, err_cnt, rdy} !== '0) begin
      bad++;
      $display("FAIL reset_hold: got bin=%0d vld=%0b dir=%0b eqnz=%0b err=%0b cnt=%0d rdy=%0b want all 0",
               bin, vld, dir, eqnz, err, err_cnt, rdy);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      total++;
      if (rdy !== 1'b0 || vld !== 1'b0 || bin !== 4'd0) begin
        bad++;
        $display("FAIL reset_init%0d: got rdy=%0b vld=%0b bin=%0d want 0 0 0", i, rdy, vld, bin);
      end
    end
    tick;
    total++;
    if (rdy !== 1'b1 || bin !== 4'd4 || vld !== 1'b0 || eqnz !== 1'b1) begin
      bad++;
      $display("FAIL reset_run: got rdy=%0b bin=%0d vld=%0b eqnz=%0b want 1 4 0 1", rdy, bin, vld, eqnz);
    end
    tick;
    total++;
    if (vld !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_quiet: got vld=%0b err=%0b want 0 0", vld, err);
    end
  endtask

  task automatic test_increment;
    logic [N-1:0] exp;
    apply_reset(4'b0000);
    for (int k = 1; k <= 20; k++) begin
      exp  = N'(k);
      gray = b2g(exp);
      tick;
      tick;
      total++;
      if (vld !== 1'b0) begin
        bad++;
        $display("FAIL inc_early k=%0d: got vld=%0b want 0", k, vld);
      end
      tick;
      total++;
      if (vld !== 1'b1 || dir !== 1'b0 || bin !== exp) begin
        bad++;
        $display("FAIL inc_step k=%0d: got vld=%0b dir=%0b bin=%0d want 1 0 %0d", k, vld, dir, bin, exp);
      end
      tick;
      total++;
      if (vld !== 1'b0) begin
        bad++;
        $display("FAIL inc_pulse k=%0d: got vld=%0b want 0", k, vld);
      end
      tick;
    end
    total++;
    if (err !== 1'b0 || err_cnt !== 8'd0) begin
      bad++;
      $display("FAIL inc_err: got err=%0b cnt=%0d want 0 0", err, err_cnt);
    end
  endtask

  task automatic test_wrap;
    logic [N-1:0] g_tab [3] = '{4'b1000, 4'b0000, 4'b1000};
    logic [N-1:0] b_tab [3] = '{4'd15, 4'd0, 4'd15};
    logic         d_tab [3] = '{1'b0, 1'b0, 1'b1};
    logic         z_tab [3] = '{1'b1, 1'b0, 1'b1};
    apply_reset(4'b1001);
    total++;
    if (bin !== 4'd14) begin
      bad++;
      $display("FAIL wrap_start: got bin=%0d want 14", bin);
    end
    for (int i = 0; i < 3; i++) begin
      gray = g_tab[i];
      tick;
      tick;
      tick;
      total++;
      if (vld !== 1'b1 || dir !== d_tab[i] || bin !== b_tab[i] || eqnz !== z_tab[i]) begin
        bad++;
        $display("FAIL wrap_step%0d: got vld=%0b dir=%0b bin=%0d eqnz=%0b want 1 %0b %0d %0b",
                 i, vld, dir, bin, eqnz, d_tab[i], b_tab[i], z_tab[i]);
      end
      tick;
      total++;
      if (vld !== 1'b0 || dir !== d_tab[i]) begin
        bad++;
        $display("FAIL wrap_hold%0d: got vld=%0b dir=%0b want 0 %0b", i, vld, dir, d_tab[i]);
      end
    end
  endtask

  task automatic test_multibit;
    int vld_seen = 0;
    apply_reset(4'b0000);
    gray = 4'b0011;
    tick;
    tick;
    tick;
    total++;
    if (vld !== 1'b0 || err !== 1'b1 || err_cnt !== 8'd1 || dir !== 1'b0) begin
      bad++;
      $display("FAIL multi_first: got vld=%0b err=%0b cnt=%0d dir=%0b want 0 1 1 0", vld, err, err_cnt, dir);
    end
    for (int i = 0; i < 253; i++) begin
      gray = (gray == 4'b0011) ? 4'b0000 : 4'b0011;
      tick;
      vld_seen += int'(vld);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      vld_seen += int'(vld);
    end
    total++;
    if (err_cnt !== 8'd254) begin
      bad++;
      $display("FAIL multi_254: got cnt=%0d want 254", err_cnt);
    end
    for (int i = 0; i < 46; i++) begin
      gray = (gray == 4'b0011) ? 4'b0000 : 4'b0011;
      tick;
      vld_seen += int'(vld);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      vld_seen += int'(vld);
    end
    total++;
    if (err_cnt !== 8'd255 || err !== 1'b1 || rdy !== 1'b1) begin
      bad++;
      $display("FAIL multi_sat: got cnt=%0d err=%0b rdy=%0b want 255 1 1", err_cnt, err, rdy);
    end
    total++;
    if (vld_seen != 0) begin
      bad++;
      $display("FAIL multi_novld: got %0d pulses want 0", vld_seen);
    end
  endtask

  task automatic test_clear_err;
    // Bus sits at 0000 with err set; 0101 is a two-bit change landing with clr.
    gray = 4'b0101;
    tick;
    tick;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    total++;
    if (err !== 1'b0 || err_cnt !== 8'd0 || vld !== 1'b0 || rdy !== 1'b0) begin
      bad++;
      $display("FAIL clr_edge: got err=%0b cnt=%0d vld=%0b rdy=%0b want 0 0 0 0", err, err_cnt, vld, rdy);
    end
    for (int i = 0; i < 2; i++) begin
      tick;
      total++;
      if (rdy !== 1'b0 || err !== 1'b0) begin
        bad++;
        $display("FAIL clr_init%0d: got rdy=%0b err=%0b want 0 0", i, rdy, err);
      end
    end
    tick;
    total++;
    if (rdy !== 1'b1 || err !== 1'b0 || err_cnt !== 8'd0 || bin !== 4'd6) begin
      bad++;
      $display("FAIL clr_run: got rdy=%0b err=%0b cnt=%0d bin=%0d want 1 0 0 6", rdy, err, err_cnt, bin);
    end
    gray = 4'b0100;
    tick;
    tick;
    tick;
    total++;
    if (vld !== 1'b1 || dir !== 1'b0 || bin !== 4'd7 || err !== 1'b0) begin
      bad++;
      $display("FAIL clr_step: got vld=%0b dir=%0b bin=%0d err=%0b want 1 0 7 0", vld, dir, bin, err);
    end
  endtask

  task automatic test_reset_midstream;
    logic [N-1:0] seq_a [2] = '{4'd9, 4'd8};
    logic [N-1:0] seq_b [2] = '{4'd6, 4'd5};
    apply_reset(b2g(4'd10));
    for (int i = 0; i < 2; i++) begin
      gray = b2g(seq_a[i]);
      tick;
      tick;
      tick;
      total++;
      if (vld !== 1'b1 || dir !== 1'b1 || bin !== seq_a[i]) begin
        bad++;
        $display("FAIL mid_down%0d: got vld=%0b dir=%0b bin=%0d want 1 1 %0d", i, vld, dir, bin, seq_a[i]);
      end
      tick;
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bin, vld, dir, eqnz, err, err_cnt, rdy} !== '0) begin
      bad++;
      $display("FAIL mid_async: got bin=%0d vld=%0b dir=%0b eqnz=%0b err=%0b cnt=%0d rdy=%0b want all 0",
               bin, vld, dir, eqnz, err, err_cnt, rdy);
    end
    gray = b2g(4'd7);
    tick;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      total++;
      if (rdy !== 1'b0 || vld !== 1'b0) begin
        bad++;
        $display("FAIL mid_init%0d: got rdy=%0b vld=%0b want 0 0", i, rdy, vld);
      end
    end
    tick;
    total++;
    if (rdy !== 1'b1 || bin !== 4'd7 || vld !== 1'b0) begin
      bad++;
      $display("FAIL mid_run: got rdy=%0b bin=%0d vld=%0b want 1 7 0", rdy, bin, vld);
    end
    for (int i = 0; i < 2; i++) begin
      gray = b2g(seq_b[i]);
      tick;
      tick;
      tick;
      total++;
      if (vld !== 1'b1 || dir !== 1'b1 || bin !== seq_b[i]) begin
        bad++;
        $display("FAIL mid_resume%0d: got vld=%0b dir=%0b bin=%0d want 1 1 %0d", i, vld, dir, bin, seq_b[i]);
      end
      tick;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    gray  = '0;
    test_reset();
    test_increment();
    test_wrap();
    test_multibit();
    test_clear_err();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
